lsu_ecc_wb_ctl: RTL and testbench
=================================

Name: lsu_ecc_wb_ctl

Overview:
- Controller for DCCM single-bit-error repair. It captures the SEC-corrected lo/hi bank words produced in DC3 and sequences their writeback to the DCCM write port.
- It arbitrates that write port between the ECC writeback and the store-buffer drain, using a starvation limit so neither requester is locked out.
- It exposes a busy/stall indication and a saturating corrected-error counter.
- ECC check bits for the written word are generated by the existing shared store-drain encoder, which sits downstream of dccm_wr_data.

Parameters:
- DATA_WIDTH, 32, DCCM bank word width in bits (multiple of 8).
- ADDR_BITS, 16, DCCM address width.
- MAX_STALL, 4, consecutive cycles of lost arbitration after which the ECC writeback takes priority (≥1).
- CNT_WIDTH, 16, width of the corrected-error counter.

Ports:
- clk  in  1  core clock.
- rst_l  in  1  reset, asynchronous, active-low.
- single_ecc_error_lo_dc3  in  1  SEC on lo bank this cycle.
- single_ecc_error_hi_dc3  in  1  SEC on hi bank this cycle.
- lsu_double_ecc_error_dc3  in  1  DED on either bank; suppresses capture.
- kill_dc3  in  1  DC3 instruction flushed; suppresses capture.
- lsu_addr_dc3  in  ADDR_BITS  start address.
- end_addr_dc3  in  ADDR_BITS  end address.
- store_ecc_datafn_lo_dc3  in  DATA_WIDTH  corrected/merged lo word.
- store_ecc_datafn_hi_dc3  in  DATA_WIDTH  corrected/merged hi word.
- stbuf_wr_req  in  1  store buffer drain request.
- stbuf_wr_addr  in  ADDR_BITS  drain address.
- stbuf_data_any  in  DATA_WIDTH  drain data.
- stbuf_wr_gnt  out  1  drain granted this cycle.
- dccm_wren  out  1  DCCM write enable.
- dccm_wr_addr  out  ADDR_BITS  DCCM write address.
- dccm_wr_data  out  DATA_WIDTH  DCCM write data (to shared encoder).
- lsu_ecc_busy  out  1  writeback pending; upstream must hold new DC3 DCCM accesses.
- ecc_err_dropped  out  1  one-cycle pulse when an SEC was ignored because the block was busy.
- ecc_sec_count  out  CNT_WIDTH  saturating count of captured corrections.

Behaviour:
- **Capture condition** (cap):
  - state==IDLE & ~kill_dc3 & ~lsu_double_ecc_error_dc3 & (single_ecc_error_lo_dc3 | single_ecc_error_hi_dc3).
- **On cap, registered next cycle:**
  - pend_lo ← single_lo; addr_lo ← lsu_addr_dc3 with low log2(DATA_WIDTH/8) bits zeroed; data_lo ← store_ecc_datafn_lo_dc3.
  - pend_hi ← single_hi; addr_hi ← end_addr_dc3 aligned the same way; data_hi ← store_ecc_datafn_hi_dc3.
  - ecc_sec_count += pend count (1 or 2), saturating at all-ones.
- **FSM, states IDLE, WB_LO, WB_HI:**
  - IDLE → WB_LO if cap & single_lo; → WB_HI if cap & ~single_lo & single_hi; else stay.
  - WB_LO: ecc_req=1. On ecc_gnt, clear pend_lo; → WB_HI if pend_hi, else → IDLE.
  - WB_HI: ecc_req=1. On ecc_gnt, clear pend_hi; → IDLE.
- **Arbitration** (combinational, same cycle):
  - starve = (stall_cnt ≥ MAX_STALL).
  - ecc_gnt = ecc_req & (~stbuf_wr_req | starve).
  - stbuf_wr_gnt = stbuf_wr_req & ~ecc_gnt.
  - dccm_wren = ecc_gnt | stbuf_wr_gnt.
  - addr/data: the current ECC entry when ecc_gnt, otherwise stbuf_wr_addr/stbuf_data_any.
- **stall_cnt:**
  - Width $clog2(MAX_STALL+1).
  - Increments when ecc_req & ~ecc_gnt, saturating at MAX_STALL.
  - Clears on ecc_gnt.
  - Holds 0 in IDLE.
- **lsu_ecc_busy** = (state != IDLE). It is low in the capture cycle itself and high from the next cycle until the cycle after the last ECC grant.
- **Busy-drop:** ecc_err_dropped = (state != IDLE) & ~kill_dc3 & ~DED & (single_lo | single_hi). The error is not captured and not counted.
- **Simultaneous capture and grant:** cannot occur, because capture happens only in IDLE.
- **Write latency:** the first ECC write occurs at earliest 1 cycle after cap. A dual-bank error needs 2 ECC write cycles minimum, always lo before hi.
- **Reset:**
  - state=IDLE; pend_lo=pend_hi=0; stall_cnt=0; ecc_sec_count=0; data/addr regs=0.
  - Outputs then follow stbuf directly: stbuf_wr_gnt=stbuf_wr_req, busy=0, dropped=0.
- **Reset mid-writeback:** pending entries are discarded; no partial write is generated after rst_l deasserts.

Test Plan:
- Lo-only SEC: addr=0x0104, data_lo=0xDEADBEEF, stbuf idle → cycle+1 dccm_wren=1, addr=0x0104, data=0xDEADBEEF; busy high 1 cycle; count=1.
- Dual SEC: lsu_addr=0x0006, end_addr=0x000A → writes 0x0004 then 0x0008 on consecutive cycles; count=2.
- Starvation with MAX_STALL=4 and stbuf_wr_req held high: stbuf granted 4 cycles, ECC granted on the 5th, stbuf granted again on the 6th.
- DED or kill_dc3 together with an SEC → no capture, busy=0, count unchanged, no ECC write.
- SEC arriving while in WB_LO → ecc_err_dropped pulses 1 cycle; count unchanged; the original write completes.
- Assert rst_l=0 in WB_HI, then release → state IDLE, no ECC write follows; counter saturation test from preload: count 0xFFFF + SEC → stays 0xFFFF.

Source files
------------

// File: rtl/lsu_ecc_wb_ctl.sv
// ---------------------------------------------------------------------------
// lsu_ecc_wb_ctl
//
// Repairs DCCM single-bit errors. It captures the SEC-corrected lo/hi bank
// words seen in DC3 and writes them back through the DCCM write port, which
// is shared with the store-buffer drain. The ECC writeback wins arbitration
// when the store buffer is idle, or once it has lost MAX_STALL cycles in a
// row. Check bits are added downstream by the shared store-drain encoder.
//
// Handshake: a requester owns the DCCM port in exactly the cycle its grant
// is high. A grant is a combinational function of the request and the
// registered state in that same cycle. The store buffer keeps stbuf_wr_req
// asserted until it sees stbuf_wr_gnt. dccm_wren marks a cycle with a write.
//
// Ports:
//   clk, rst_l                 clock, asynchronous active-low reset
//   single_ecc_error_lo/hi_dc3 SEC seen on the lo/hi bank this cycle
//   lsu_double_ecc_error_dc3   DED on either bank (no capture)
//   kill_dc3                   DC3 instruction flushed (no capture)
//   lsu_addr_dc3, end_addr_dc3 start/end address of the access
//   store_ecc_datafn_lo/hi_dc3 corrected lo/hi words
//   stbuf_wr_req/addr, stbuf_data_any  store-buffer drain request
//   stbuf_wr_gnt               drain granted this cycle
//   dccm_wren/wr_addr/wr_data  DCCM write port
//   lsu_ecc_busy               writeback pending, DC3 accesses must hold
//   ecc_err_dropped            SEC ignored because a writeback was pending
//   ecc_sec_count              saturating count of captured corrections
//   fsm_state                  current FSM state (debug visibility)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module lsu_ecc_wb_ctl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 16,
    parameter int MAX_STALL  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  single_ecc_error_lo_dc3,
    input  logic                  single_ecc_error_hi_dc3,
    input  logic                  lsu_double_ecc_error_dc3,
    input  logic                  kill_dc3,
    input  logic [ADDR_BITS-1:0]  lsu_addr_dc3,
    input  logic [ADDR_BITS-1:0]  end_addr_dc3,
    input  logic [DATA_WIDTH-1:0] store_ecc_datafn_lo_dc3,
    input  logic [DATA_WIDTH-1:0] store_ecc_datafn_hi_dc3,
    input  logic                  stbuf_wr_req,
    input  logic [ADDR_BITS-1:0]  stbuf_wr_addr,
    input  logic [DATA_WIDTH-1:0] stbuf_data_any,
    output logic                  stbuf_wr_gnt,
    output logic                  dccm_wren,
    output logic [ADDR_BITS-1:0]  dccm_wr_addr,
    output logic [DATA_WIDTH-1:0] dccm_wr_data,
    output logic                  lsu_ecc_busy,
    output logic                  ecc_err_dropped,
    output logic [CNT_WIDTH-1:0]  ecc_sec_count,
    output logic [1:0]            fsm_state
);

    localparam int OFF_BITS   = $clog2(DATA_WIDTH / 8);
    localparam int STALL_BITS = $clog2(MAX_STALL + 1);

    // Clears the byte-offset bits so the address names a whole bank word.
    localparam logic [ADDR_BITS-1:0]  ALIGN_MASK = {ADDR_BITS{1'b1}} << OFF_BITS;
    localparam logic [STALL_BITS-1:0] STALL_MAX  = STALL_BITS'(MAX_STALL);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WB_LO = 2'd1;
    localparam logic [1:0] WB_HI = 2'd2;

    logic [1:0]            state;
    logic                  pend_lo;
    logic                  pend_hi;
    logic [ADDR_BITS-1:0]  addr_lo;
    logic [ADDR_BITS-1:0]  addr_hi;
    logic [DATA_WIDTH-1:0] data_lo;
    logic [DATA_WIDTH-1:0] data_hi;
    logic [STALL_BITS-1:0] stall_cnt;

    logic                  sec_any;
    logic                  sec_valid;
    logic                  cap;
    logic                  ecc_req;
    logic                  starve;
    logic                  ecc_gnt;
    logic [ADDR_BITS-1:0]  ecc_addr;
    logic [DATA_WIDTH-1:0] ecc_data;
    logic [CNT_WIDTH:0]    cnt_sum;

    // An SEC only counts when the DC3 op survives and the word is not
    // uncorrectable; capture then depends only on whether we are free.
    assign sec_any   = single_ecc_error_lo_dc3 | single_ecc_error_hi_dc3;
    assign sec_valid = sec_any & ~kill_dc3 & ~lsu_double_ecc_error_dc3;
    assign cap       = (state == IDLE) & sec_valid;

    assign ecc_req = (state == WB_LO) | (state == WB_HI);
    assign starve  = (stall_cnt >= STALL_MAX);
    assign ecc_gnt = ecc_req & (~stbuf_wr_req | starve);

    // Lo is always written before hi, so the state selects the entry.
    assign ecc_addr = (state == WB_HI) ? addr_hi : addr_lo;
    assign ecc_data = (state == WB_HI) ? data_hi : data_lo;

    assign stbuf_wr_gnt = stbuf_wr_req & ~ecc_gnt;
    assign dccm_wren    = ecc_gnt | stbuf_wr_gnt;
    assign dccm_wr_addr = ecc_gnt ? ecc_addr : stbuf_wr_addr;
    assign dccm_wr_data = ecc_gnt ? ecc_data : stbuf_data_any;

    assign lsu_ecc_busy    = (state != IDLE);
    assign ecc_err_dropped = (state != IDLE) & sec_valid;
    assign fsm_state       = state;

    // One extra bit catches overflow so the counter can pin at all-ones.
    assign cnt_sum = {1'b0, ecc_sec_count}
                   + (CNT_WIDTH + 1)'(single_ecc_error_lo_dc3)
                   + (CNT_WIDTH + 1)'(single_ecc_error_hi_dc3);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cap && single_ecc_error_lo_dc3) begin
                        state <= WB_LO;
                    end else if (cap && single_ecc_error_hi_dc3) begin
                        state <= WB_HI;
                    end
                end
                WB_LO: begin
                    if (ecc_gnt) begin
                        state <= pend_hi ? WB_HI : IDLE;
                    end
                end
                WB_HI: begin
                    if (ecc_gnt) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            pend_lo <= 1'b0;
            pend_hi <= 1'b0;
            addr_lo <= '0;
            addr_hi <= '0;
            data_lo <= '0;
            data_hi <= '0;
        end else if (cap) begin
            pend_lo <= single_ecc_error_lo_dc3;
            pend_hi <= single_ecc_error_hi_dc3;
            addr_lo <= lsu_addr_dc3 & ALIGN_MASK;
            addr_hi <= end_addr_dc3 & ALIGN_MASK;
            data_lo <= store_ecc_datafn_lo_dc3;
            data_hi <= store_ecc_datafn_hi_dc3;
        end else if (ecc_gnt) begin
            if (state == WB_LO) begin
                pend_lo <= 1'b0;
            end
            if (state == WB_HI) begin
                pend_hi <= 1'b0;
            end
        end
    end

    // Counts consecutive lost arbitrations of the current ECC entry.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            stall_cnt <= '0;
        end else if (!ecc_req || ecc_gnt) begin
            stall_cnt <= '0;
        end else if (stall_cnt < STALL_MAX) begin
            stall_cnt <= stall_cnt + STALL_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ecc_sec_count <= '0;
        end else if (cap) begin
            ecc_sec_count <= cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}}
                                                : cnt_sum[CNT_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_lsu_ecc_wb_ctl.sv
`timescale 1ns/1ps
module tb_lsu_ecc_wb_ctl;

    logic        clk;
    logic        rst_l;
    logic        sec_lo;
    logic        sec_hi;
    logic        ded;
    logic        kill;
    logic [15:0] lsu_addr;
    logic [15:0] end_addr;
    logic [31:0] dat_lo;
    logic [31:0] dat_hi;
    logic        sb_req;
    logic [15:0] sb_addr;
    logic [31:0] sb_data;

    logic        sb_gnt;
    logic        wren;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        dropped;
    logic [15:0] count;
    logic [1:0]  st;

    // Second instance with a 2-bit counter so saturation is reachable.
    logic        s_sb_gnt;
    logic        s_wren;
    logic [15:0] s_wr_addr;
    logic [31:0] s_wr_data;
    logic        s_busy;
    logic        s_dropped;
    logic [1:0]  s_count;
    logic [1:0]  s_st;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_ecc_wb_ctl #(.DATA_WIDTH(32), .ADDR_BITS(16), .MAX_STALL(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_l(rst_l),
        .single_ecc_error_lo_dc3(sec_lo), .single_ecc_error_hi_dc3(sec_hi),
        .lsu_double_ecc_error_dc3(ded), .kill_dc3(kill),
        .lsu_addr_dc3(lsu_addr), .end_addr_dc3(end_addr),
        .store_ecc_datafn_lo_dc3(dat_lo), .store_ecc_datafn_hi_dc3(dat_hi),
        .stbuf_wr_req(sb_req), .stbuf_wr_addr(sb_addr), .stbuf_data_any(sb_data),
        .stbuf_wr_gnt(sb_gnt), .dccm_wren(wren), .dccm_wr_addr(wr_addr),
        .dccm_wr_data(wr_data), .lsu_ecc_busy(busy), .ecc_err_dropped(dropped),
        .ecc_sec_count(count), .fsm_state(st)
    );

    lsu_ecc_wb_ctl #(.DATA_WIDTH(32), .ADDR_BITS(16), .MAX_STALL(4), .CNT_WIDTH(2)) sat_dut (
        .clk(clk), .rst_l(rst_l),
        .single_ecc_error_lo_dc3(sec_lo), .single_ecc_error_hi_dc3(sec_hi),
        .lsu_double_ecc_error_dc3(ded), .kill_dc3(kill),
        .lsu_addr_dc3(lsu_addr), .end_addr_dc3(end_addr),
        .store_ecc_datafn_lo_dc3(dat_lo), .store_ecc_datafn_hi_dc3(dat_hi),
        .stbuf_wr_req(sb_req), .stbuf_wr_addr(sb_addr), .stbuf_data_any(sb_data),
        .stbuf_wr_gnt(s_sb_gnt), .dccm_wren(s_wren), .dccm_wr_addr(s_wr_addr),
        .dccm_wr_data(s_wr_data), .lsu_ecc_busy(s_busy), .ecc_err_dropped(s_dropped),
        .ecc_sec_count(s_count), .fsm_state(s_st)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge; inputs change there and
    // checks happen 1ns later, well away from either edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr_dc3();
        sec_lo   = 1'b0;
        sec_hi   = 1'b0;
        ded      = 1'b0;
        kill     = 1'b0;
        lsu_addr = '0;
        end_addr = '0;
        dat_lo   = '0;
        dat_hi   = '0;
    endtask

    task automatic sec(input logic lo, input logic hi, input logic [15:0] a, input logic [15:0] e,
                       input logic [31:0] dl, input logic [31:0] dh);
        sec_lo   = lo;
        sec_hi   = hi;
        lsu_addr = a;
        end_addr = e;
        dat_lo   = dl;
        dat_hi   = dh;
    endtask

    initial begin
        clr_dc3();
        sb_req  = 1'b1;
        sb_addr = 16'h0010;
        sb_data = 32'h1111_1111;
        rst_l   = 1'b0;
        #2;
        // Reset: outputs follow the store buffer directly.
        chk("rst_sb_gnt", 32'(sb_gnt), 32'd1);
        chk("rst_wren", 32'(wren), 32'd1);
        chk("rst_addr", 32'(wr_addr), 32'h0010);
        chk("rst_data", wr_data, 32'h1111_1111);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_state", 32'(st), 32'd0);
        sec_lo = 1'b1;
        settle();
        chk("rst_dropped", 32'(dropped), 32'd0);
        sec_lo = 1'b0;
        step();
        step();
        rst_l  = 1'b1;
        sb_req = 1'b0;
        step();

        // Lo-only SEC, store buffer idle
        sec(1'b1, 1'b0, 16'h0104, 16'h0104, 32'hDEAD_BEEF, 32'h0BAD_0BAD);
        settle();
        chk("lo_cap_busy", 32'(busy), 32'd0);
        chk("lo_cap_wren", 32'(wren), 32'd0);
        step();
        clr_dc3();
        settle();
        chk("lo_wren", 32'(wren), 32'd1);
        chk("lo_addr", 32'(wr_addr), 32'h0104);
        chk("lo_data", wr_data, 32'hDEAD_BEEF);
        chk("lo_busy", 32'(busy), 32'd1);
        chk("lo_count", 32'(count), 32'd1);
        step();
        chk("lo_done_busy", 32'(busy), 32'd0);
        chk("lo_done_wren", 32'(wren), 32'd0);

        // Dual SEC: lo then hi on consecutive cycles, addresses word-aligned
        sec(1'b1, 1'b1, 16'h0006, 16'h000A, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
        step();
        clr_dc3();
        settle();
        chk("dual_lo_wren", 32'(wren), 32'd1);
        chk("dual_lo_addr", 32'(wr_addr), 32'h0004);
        chk("dual_lo_data", wr_data, 32'hA5A5_A5A5);
        chk("dual_count", 32'(count), 32'd3);
        step();
        chk("dual_hi_wren", 32'(wren), 32'd1);
        chk("dual_hi_addr", 32'(wr_addr), 32'h0008);
        chk("dual_hi_data", wr_data, 32'h5A5A_5A5A);
        chk("dual_hi_state", 32'(st), 32'd2);
        step();
        chk("dual_done_busy", 32'(busy), 32'd0);

        // Starvation: store buffer wins 4 cycles, ECC takes the 5th
        sb_req  = 1'b1;
        sb_addr = 16'h0200;
        sb_data = 32'hCAFE_F00D;
        sec(1'b1, 1'b0, 16'h0300, 16'h0300, 32'h1234_5678, 32'h0);
        settle();
        chk("stv_cap_sb_gnt", 32'(sb_gnt), 32'd1);
        step();
        clr_dc3();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("stv_sb_gnt%0d", i), 32'(sb_gnt), 32'd1);
            chk($sformatf("stv_sb_addr%0d", i), 32'(wr_addr), 32'h0200);
            step();
        end
        chk("stv_ecc_sb_gnt", 32'(sb_gnt), 32'd0);
        chk("stv_ecc_wren", 32'(wren), 32'd1);
        chk("stv_ecc_addr", 32'(wr_addr), 32'h0300);
        chk("stv_ecc_data", wr_data, 32'h1234_5678);
        step();
        chk("stv_after_sb_gnt", 32'(sb_gnt), 32'd1);
        chk("stv_after_busy", 32'(busy), 32'd0);
        chk("stv_count", 32'(count), 32'd4);
        sb_req = 1'b0;

        // DED and kill suppress capture
        sec(1'b1, 1'b0, 16'h0400, 16'h0400, 32'h7777_7777, 32'h0);
        ded = 1'b1;
        settle();
        chk("ded_dropped", 32'(dropped), 32'd0);
        step();
        clr_dc3();
        settle();
        chk("ded_busy", 32'(busy), 32'd0);
        chk("ded_wren", 32'(wren), 32'd0);
        chk("ded_count", 32'(count), 32'd4);
        sec(1'b0, 1'b1, 16'h0400, 16'h0404, 32'h0, 32'h8888_8888);
        kill = 1'b1;
        step();
        clr_dc3();
        settle();
        chk("kill_busy", 32'(busy), 32'd0);
        chk("kill_wren", 32'(wren), 32'd0);
        chk("kill_count", 32'(count), 32'd4);

        // SEC while busy is dropped; original writes still complete
        sec(1'b1, 1'b1, 16'h0040, 16'h0044, 32'h0101_0101, 32'h0202_0202);
        step();
        sec(1'b1, 1'b0, 16'h0900, 16'h0900, 32'hFFFF_0000, 32'h0);
        settle();
        chk("drop_pulse", 32'(dropped), 32'd1);
        chk("drop_lo_addr", 32'(wr_addr), 32'h0040);
        chk("drop_lo_data", wr_data, 32'h0101_0101);
        step();
        clr_dc3();
        settle();
        chk("drop_pulse_end", 32'(dropped), 32'd0);
        chk("drop_hi_addr", 32'(wr_addr), 32'h0044);
        chk("drop_hi_data", wr_data, 32'h0202_0202);
        chk("drop_count", 32'(count), 32'd6);
        step();
        chk("drop_done_busy", 32'(busy), 32'd0);
        chk("drop_done_count", 32'(count), 32'd6);

        // Reset while in WB_HI discards the pending hi write
        sec(1'b1, 1'b1, 16'h0080, 16'h0084, 32'h1357_9BDF, 32'h2468_ACE0);
        step();
        clr_dc3();
        step();
        chk("mid_state_hi", 32'(st), 32'd2);
        rst_l = 1'b0;
        settle();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_wren", 32'(wren), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        step();
        rst_l = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("mid_post_wren%0d", i), 32'(wren), 32'd0);
            chk($sformatf("mid_post_state%0d", i), 32'(st), 32'd0);
        end

        // Counter saturation on the 2-bit instance: 0 -> 2 -> 3 (pinned) -> 3
        sec(1'b1, 1'b1, 16'h0010, 16'h0014, 32'h1, 32'h2);
        step();
        clr_dc3();
        step();
        step();
        chk("sat_cnt_a", 32'(s_count), 32'd2);
        sec(1'b1, 1'b1, 16'h0020, 16'h0024, 32'h3, 32'h4);
        step();
        clr_dc3();
        step();
        step();
        chk("sat_cnt_b", 32'(s_count), 32'd3);
        sec(1'b1, 1'b0, 16'h0030, 16'h0030, 32'h5, 32'h0);
        step();
        clr_dc3();
        step();
        chk("sat_cnt_c", 32'(s_count), 32'd3);
        chk("sat_main_count", 32'(count), 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
